// File: rtl/wb_timer_pkg.sv
// Wishbone payload types, register map and CTRL layout shared by the timer peripheral.
package wb_timer_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = WB_DW / 8;

    localparam logic [3:0] TIMER_MASK_ADDR    = 4'hf;
    localparam logic [3:0] TIMER_CTRL_OFS     = 4'h0;
    localparam logic [3:0] TIMER_LOAD_OFS     = 4'h4;
    localparam logic [3:0] TIMER_COUNT_OFS    = 4'h8;
    localparam logic [3:0] TIMER_STATUS_OFS   = 4'hc;

    localparam int unsigned TIMER_EN_BIT       = 0;
    localparam int unsigned TIMER_AUTO_BIT     = 1;
    localparam int unsigned TIMER_IRQEN_BIT    = 2;
    localparam int unsigned TIMER_PRESCALE_LSB = 16;
    localparam int unsigned TIMER_PRESCALE_MAX = 16;

    typedef struct packed {
        logic [WB_AW-1:0] a_adr;
        logic [WB_DW-1:0] a_dat;
        logic             a_we;
        logic [WB_SW-1:0] a_sel;
        logic             a_stb;
        logic             a_cyc;
    } wb_h2d_t;

    typedef struct packed {
        logic [WB_DW-1:0] d_dat;
        logic             d_ack;
    } wb_d2h_t;

    // CTRL register image; prescale bits above PRESCALE_W are masked off by the timer.
    typedef struct packed {
        logic [TIMER_PRESCALE_MAX-1:0] prescale;
        logic [12:0]                   rsvd;
        logic                          irq_en;
        logic                          auto_rl;
        logic                          en;
    } timer_ctrl_t;

    function automatic logic [WB_DW-1:0] wb_merge(input logic [WB_DW-1:0] old_v,
                                                  input logic [WB_DW-1:0] new_v,
                                                  input logic [WB_SW-1:0] sel);
        logic [WB_DW-1:0] res;
        res = old_v;
        for (int i = 0; i < int'(WB_SW); i++) begin
            if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Free-running prescale counter producing a one-cycle tick every PRESCALE+1 cycles while enabled.
module wb_timer_prescaler
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick_c
);

    logic [PRESCALE_W-1:0] pcnt_q;

    // >= keeps the period bounded if PRESCALE is lowered below the running count.
    assign tick_c = en & (pcnt_q >= prescale);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt_q <= '0;
        end else if (!en || restart || tick_c) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone slave timer: CTRL/LOAD/COUNT/STATUS registers, prescaled down-counter and level IRQ.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int unsigned  PRESCALE_W = 16,
    parameter logic [31:0]  RESET_LOAD = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    resetn,
    input  wb_h2d_t wb_i,
    output wb_d2h_t wb_o,
    output logic    irq_o
);

    localparam logic [1:0] REG_CTRL   = TIMER_CTRL_OFS[3:2];
    localparam logic [1:0] REG_LOAD   = TIMER_LOAD_OFS[3:2];
    localparam logic [1:0] REG_COUNT  = TIMER_COUNT_OFS[3:2];
    localparam logic [1:0] REG_STATUS = TIMER_STATUS_OFS[3:2];

    localparam logic [WB_DW-1:0] CTRL_MASK =
        {16'((32'd1 << PRESCALE_W) - 32'd1), 13'd0, 3'b111};

    timer_ctrl_t      ctrl_q, ctrl_nxt;
    logic [WB_DW-1:0] load_q, load_nxt;
    logic [WB_DW-1:0] count_q, count_nxt;
    logic             expired_q, expired_nxt;
    logic             ack_q;
    logic [WB_DW-1:0] dat_q;
    logic             irq_q;

    logic             accept_c;
    logic             wr_c;
    logic [1:0]       reg_sel_c;
    logic [WB_DW-1:0] rd_data_c;
    logic             tick_c;
    logic             expire_c;
    logic             clear_c;
    logic             restart_c;
    logic             unused_adr;

    assign accept_c  = wb_i.a_cyc & wb_i.a_stb & ~ack_q;
    assign wr_c      = accept_c & wb_i.a_we;
    assign reg_sel_c = wb_i.a_adr[3:2];
    assign unused_adr = ^{wb_i.a_adr[WB_AW-1:4], wb_i.a_adr[1:0]};

    assign expire_c  = tick_c & (count_q == 32'd1);
    assign clear_c   = wr_c & (reg_sel_c == REG_STATUS) & wb_i.a_sel[0] & wb_i.a_dat[0];
    assign restart_c = wr_c & (reg_sel_c == REG_CTRL) & ~ctrl_q.en & ctrl_nxt.en;

    wb_timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .resetn   (resetn),
        .en       (ctrl_q.en),
        .restart  (restart_c),
        .prescale (ctrl_q.prescale[PRESCALE_W-1:0]),
        .tick_c   (tick_c)
    );

    // Read mux sees pre-update register values.
    always_comb begin
        rd_data_c = '0;
        case (reg_sel_c)
            REG_CTRL:   rd_data_c = ctrl_q;
            REG_LOAD:   rd_data_c = load_q;
            REG_COUNT:  rd_data_c = count_q;
            REG_STATUS: rd_data_c = {30'd0, ctrl_q.en, expired_q};
            default:    rd_data_c = '0;
        endcase
    end

    // Counter event first, then software writes override it; expiry set beats W1C.
    always_comb begin
        ctrl_nxt    = ctrl_q;
        load_nxt    = load_q;
        count_nxt   = count_q;
        expired_nxt = expire_c | (expired_q & ~clear_c);

        if (tick_c) begin
            if (count_q > 32'd1) begin
                count_nxt = count_q - 32'd1;
            end else if (expire_c) begin
                if (ctrl_q.auto_rl) begin
                    count_nxt = load_q;
                end else begin
                    count_nxt   = '0;
                    ctrl_nxt.en = 1'b0;
                end
            end
        end

        if (wr_c) begin
            case (reg_sel_c)
                REG_CTRL:  ctrl_nxt  = timer_ctrl_t'(wb_merge(ctrl_nxt, wb_i.a_dat, wb_i.a_sel)
                                                     & CTRL_MASK);
                REG_LOAD:  load_nxt  = wb_merge(load_q, wb_i.a_dat, wb_i.a_sel);
                REG_COUNT: count_nxt = wb_merge(count_q, wb_i.a_dat, wb_i.a_sel);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q    <= '0;
            load_q    <= RESET_LOAD;
            count_q   <= '0;
            expired_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_nxt;
            load_q    <= load_nxt;
            count_q   <= count_nxt;
            expired_q <= expired_nxt;
            ack_q     <= accept_c;
            dat_q     <= accept_c ? rd_data_c : '0;
            irq_q     <= expired_nxt & ctrl_nxt.irq_en;
        end
    end

    assign wb_o  = '{d_dat: dat_q, d_ack: ack_q};
    assign irq_o = irq_q;

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone slave timer peripheral, mapped at TIMER_BASE_ADDR with a 16-byte window (TIMER_MASK_ADDR = 0xf).
- Consumes wb_h2d_t from the SoC interconnect and returns wb_d2h_t.
- Provides a prescaled 32-bit down-counter with one-shot and auto-reload modes, a sticky expiry flag and a level interrupt to the PicoRV32 IRQ vector.
- Address decode to this block is done upstream; the block uses only a_adr[3:2].

Parameters:
- PRESCALE_W, 16: width of the prescale field in CTRL[16+PRESCALE_W-1:16]; range 1..16.
- RESET_LOAD, 32'h0000_0000: reset value of the LOAD register.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- wb_i  in  wb_h2d_t  Wishbone request (a_adr, a_dat, a_we, a_sel, a_stb, a_cyc).
- wb_o  out  wb_d2h_t  Wishbone response (d_dat, d_ack).
- irq_o  out  1  timer interrupt, level, active-high.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (resetn).
- On reset, the following go to 0: CTRL, COUNT, STATUS, the prescale counter, d_ack, d_dat and irq_o. LOAD goes to RESET_LOAD.
- Register map, selected by a_adr[3:2]:
  - 0x0 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN, [16+PRESCALE_W-1:16] PRESCALE. All other bits read 0.
  - 0x4 LOAD: reload value, R/W.
  - 0x8 COUNT: current count, R/W.
  - 0xC STATUS: bit0 EXPIRED (sticky, write-1-to-clear), bit1 RUNNING (read-only, equals EN). Other bits read 0.
- Wishbone handshake:
  - A request is accepted when a_cyc & a_stb & ~d_ack.
  - d_ack is registered and pulses high for exactly one cycle, 1 cycle after acceptance. Back-to-back requests therefore get an ack every other cycle.
  - d_dat is valid only while d_ack=1 and reads 0 otherwise.
  - Writes honour a_sel per byte for CTRL, LOAD and COUNT. For STATUS, only a_sel[0] is honoured.
  - A register write takes effect on the same edge that raises d_ack.
  - Read data is the register value before any same-cycle counter update.
- Prescaler:
  - The prescale counter counts 0..PRESCALE while EN=1. tick is asserted when the counter equals PRESCALE, and the counter then wraps to 0.
  - The tick period is PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - While EN=0, the prescale counter is held at 0.
  - Any write that changes EN from 0 to 1 forces the prescale counter to 0.
- Counter, on tick with EN=1:
  - COUNT>1: COUNT decrements by 1.
  - COUNT==1: expiry. EXPIRED is set. If AUTO=1, COUNT loads LOAD. If AUTO=0, COUNT becomes 0 and EN clears.
  - COUNT==0: no change and no expiry; EN stays set. This covers LOAD=0 with AUTO=1, which never expires.
- Interrupt: irq_o = EXPIRED & IRQ_EN, driven from flops. It rises on the same edge that sets EXPIRED, or on the edge that sets IRQ_EN while EXPIRED=1.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the write wins and the decrement is dropped.
  - A software write to CTRL in the same cycle as a one-shot expiry: the CTRL write wins for EN, but EXPIRED is still set.
  - A STATUS W1C in the same cycle as an expiry: set wins and EXPIRED stays 1.
  - A write to LOAD does not affect COUNT until the next reload.
- Reset mid-transaction: a pending ack is dropped. The master must restart the cycle.

Decomposition:
- Add to picorv32_pkg:
  - TIMER_CTRL_OFS=0x0, TIMER_LOAD_OFS=0x4, TIMER_COUNT_OFS=0x8, TIMER_STATUS_OFS=0xC.
  - CTRL bit-position constants: TIMER_EN_BIT, TIMER_AUTO_BIT, TIMER_IRQEN_BIT, TIMER_PRESCALE_LSB.
  - A packed typedef timer_ctrl_t.
- One sub-module, wb_timer_prescaler:
  - Inputs: clk, resetn, en, restart, prescale.
  - Output: a tick pulse.
- The top level holds the Wishbone slave logic, registers, counter and IRQ.

Test Plan:
- Register access: reset, then read all 4 offsets -> 0, 0 (RESET_LOAD), 0, 0. Write LOAD=0xDEADBEEF with a_sel=4'b0011 -> reads 0x0000BEEF. Every ack is exactly 1 cycle wide.
- Auto-reload:
  - Setup: LOAD=5, COUNT=5, CTRL=EN|AUTO|IRQ_EN with PRESCALE=0.
  - COUNT runs 4,3,2,1 on successive cycles, then reloads to 5. EXPIRED=1 and irq_o=1 on the reload edge; the sequence repeats every 5 cycles.
  - Write STATUS=1 -> irq_o drops.
- One-shot with prescale:
  - Setup: PRESCALE=3, COUNT=2, CTRL=EN.
  - Expiry occurs 8 cycles after enable. COUNT=0, EN=0, RUNNING=0, EXPIRED=1.
  - irq_o stays 0 because IRQ_EN=0. Setting IRQ_EN afterwards -> irq_o=1 on the write edge.
- Collision, COUNT write: a COUNT write of 0x100 lands on a tick cycle -> COUNT reads 0x100, not 0xFF.
- Collision, STATUS W1C: a STATUS W1C lands on an expiry cycle -> EXPIRED remains 1.
- Asynchronous reset mid-count: assert resetn=0 between clock edges while COUNT=3 and d_ack is pending -> all outputs are 0 immediately. After release, the timer stays idle.
